// File: rtl/load_store_unit.sv
// RV64 load/store initiator for dataMemory: lane extract/extend on loads, read-modify-write on sub-word stores.
// Build option: define LSU_MISALIGN_TRAP_EN to reject any access whose address is not a multiple of its size.
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [63:0] reqAddr,
  input  logic [63:0] reqWData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [63:0] rspData,
  output logic        rspErr,
  output logic [63:0] memAddr,
  output logic [63:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [63:0] memReadData
);

  // state  | meaning
  // IDLE   | ready, latch request on accept
  // LOAD   | memory read, extract and extend lane into rspData
  // RMW_RD | memory read into merge buffer for sb/sh/sw
  // WR     | memory write of merged doubleword (or full sd data)
  // RESP   | hold response until rspReady
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WR, RESP} stateT;

  localparam logic [63:0] MemLimit = 64'(MEM_BYTES);

  stateT       state;
  logic [63:0] baseQ;
  logic [2:0]  laneQ;
  logic [2:0]  funct3Q;
  logic [63:0] wDataQ;
  logic [63:0] mergeBuf;
  logic [63:0] rspDataQ;
  logic        rspErrQ;

  logic [3:0]  reqSize;
  logic [63:0] reqBase;
  logic        funcErr;
  logic        rangeErr;
  logic        crossErr;
  logic        alignErr;
  logic        reqErr;

  always_comb begin
    case (reqFunct3[1:0])
      2'd0:    reqSize = 4'd1;
      2'd1:    reqSize = 4'd2;
      2'd2:    reqSize = 4'd4;
      default: reqSize = 4'd8;
    endcase
  end

  assign reqBase  = {reqAddr[63:3], 3'b000};
  assign funcErr  = reqWrite ? reqFunct3[2] : (reqFunct3 == 3'b111);
  assign rangeErr = (reqBase >= MemLimit);
  assign crossErr = (({1'b0, reqAddr[2:0]} + reqSize) > 4'd8);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [2:0] alignMask;
  always_comb begin
    case (reqFunct3[1:0])
      2'd0:    alignMask = 3'b000;
      2'd1:    alignMask = 3'b001;
      2'd2:    alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
  end
  assign alignErr = ((reqAddr[2:0] & alignMask) != 3'b000);
`else
  assign alignErr = 1'b0;
`endif

  assign reqErr = funcErr | rangeErr | crossErr | alignErr;

  logic [63:0] laneData;
  logic [63:0] loadExt;

  assign laneData = memReadData >> {laneQ, 3'b000};

  always_comb begin
    case (funct3Q)
      3'b000:  loadExt = {{56{laneData[7]}}, laneData[7:0]};
      3'b001:  loadExt = {{48{laneData[15]}}, laneData[15:0]};
      3'b010:  loadExt = {{32{laneData[31]}}, laneData[31:0]};
      3'b100:  loadExt = {56'd0, laneData[7:0]};
      3'b101:  loadExt = {48'd0, laneData[15:0]};
      3'b110:  loadExt = {32'd0, laneData[31:0]};
      default: loadExt = laneData;
    endcase
  end

  // sd has lane 0 and an all-ones mask, so the merge reduces to wDataQ for it
  logic [63:0] sizeMask;
  logic [63:0] laneMask;
  logic [63:0] mergedData;

  always_comb begin
    case (funct3Q[1:0])
      2'd0:    sizeMask = 64'h0000_0000_0000_00FF;
      2'd1:    sizeMask = 64'h0000_0000_0000_FFFF;
      2'd2:    sizeMask = 64'h0000_0000_FFFF_FFFF;
      default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign laneMask   = sizeMask << {laneQ, 3'b000};
  assign mergedData = (mergeBuf & ~laneMask) | ((wDataQ << {laneQ, 3'b000}) & laneMask);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      baseQ    <= '0;
      laneQ    <= '0;
      funct3Q  <= '0;
      wDataQ   <= '0;
      mergeBuf <= '0;
      rspDataQ <= '0;
      rspErrQ  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            baseQ    <= reqBase;
            laneQ    <= reqAddr[2:0];
            funct3Q  <= reqFunct3;
            wDataQ   <= reqWData;
            rspDataQ <= '0;
            rspErrQ  <= reqErr;
            if (reqErr)                      state <= RESP;
            else if (!reqWrite)              state <= LOAD;
            else if (reqFunct3[1:0] == 2'd3) state <= WR;
            else                             state <= RMW_RD;
          end
        end
        LOAD: begin
          rspDataQ <= loadExt;
          state    <= RESP;
        end
        RMW_RD: begin
          mergeBuf <= memReadData;
          state    <= WR;
        end
        WR: state <= RESP;
        RESP: if (rspReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // memory strobes decode straight from state so an async reset kills them at once
  assign reqReady     = resetN && (state == IDLE);
  assign memRead      = (state == LOAD) || (state == RMW_RD);
  assign memWrite     = (state == WR);
  assign memAddr      = (memRead || memWrite) ? baseQ : '0;
  assign memWriteData = memWrite ? mergedData : '0;
  assign rspValid     = (state == RESP);
  assign rspData      = rspDataQ;
  assign rspErr       = rspErrQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 64-byte dataMemory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [2:0]  reqFunct3 = 3'd0;
  logic [63:0] reqAddr = '0;
  logic [63:0] reqWData = '0;
  logic        rspValid;
  logic        rspReady = 1'b1;
  logic [63:0] rspData;
  logic        rspErr;
  logic [63:0] memAddr;
  logic [63:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [63:0] memReadData;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
    .memAddr(memAddr), .memWriteData(memWriteData), .memRead(memRead),
    .memWrite(memWrite), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [8];
  initial begin
    mem[0] = 64'h009A_84B3_0F05_3483;
    mem[1] = 64'h1122_3344_5566_7788;
    mem[2] = 64'h0;
    mem[3] = 64'h0706_0504_0302_0100;
    mem[4] = 64'h0;
    mem[5] = 64'h0;
    mem[6] = 64'h0;
    mem[7] = 64'h0;
  end
  assign memReadData = mem[memAddr[5:3]];
  always @(posedge clk) if (memWrite) mem[memAddr[5:3]] <= memWriteData;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          nRd;
    int          nWr;
    logic [63:0] wData;
  } expT;

  expT expQ[$];
  int  nChecks = 0;
  int  nFail = 0;
  int  cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, exp);
    end
  endtask

  function automatic expT mk(input logic [63:0] d, input logic e, input int lat,
                             input int nRd, input int nWr, input logic [63:0] wd);
    expT r;
    r.data = d; r.err = e; r.lat = lat; r.nRd = nRd; r.nWr = nWr; r.wData = wd;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: tracks latency and memory activity per transaction, pops on response handshake
  int          acceptEdge = 0;
  int          firstEdge = 0;
  int          rdCnt = 0;
  int          wrCnt = 0;
  logic        seen = 1'b0;
  logic [63:0] heldData = '0;
  logic        heldErr = 1'b0;
  logic [63:0] lastW = '0;
  initial forever begin
    @(negedge clk);
    if (!resetN) begin
      seen = 1'b0; rdCnt = 0; wrCnt = 0;
    end else begin
      if (reqValid && reqReady) begin
        acceptEdge = cyc + 1; rdCnt = 0; wrCnt = 0; seen = 1'b0;
      end
      if (memRead && memWrite) check("memRead and memWrite exclusive", 64'd1, 64'd0);
      if (memRead || memWrite)
        check("memAddr aligned and in range", 64'(memAddr[2:0] == 3'd0 && memAddr < 64'd64), 64'd1);
      if (memRead) rdCnt++;
      if (memWrite) begin
        wrCnt++;
        lastW = memWriteData;
      end
      if (rspValid) begin
        check("reqReady low in RESP", 64'(reqReady), 64'd0);
        if (!seen) begin
          seen = 1'b1; firstEdge = cyc + 1; heldData = rspData; heldErr = rspErr;
        end else begin
          check("rspData stable", rspData, heldData);
          check("rspErr stable", 64'(rspErr), 64'(heldErr));
        end
        if (rspReady) begin
          if (expQ.size() == 0) begin
            check("unexpected response", 64'd1, 64'd0);
          end else begin
            expT e;
            e = expQ.pop_front();
            check("rspData", rspData, e.data);
            check("rspErr", 64'(rspErr), 64'(e.err));
            check("rspValid latency", 64'(firstEdge - acceptEdge), 64'(e.lat));
            check("memRead cycles", 64'(rdCnt), 64'(e.nRd));
            check("memWrite cycles", 64'(wrCnt), 64'(e.nWr));
            if (e.nWr > 0) check("memWriteData", lastW, e.wData);
          end
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic doPush, input expT e);
    logic ok;
    if (doPush) expQ.push_back(e);
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddr = a; reqWData = wd;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (reqReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) check("drain outstanding responses", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  localparam logic [63:0] D0 = 64'h009A_84B3_0F05_3483;

  initial begin
    logic ok;
    #3;
    check("reset reqReady", 64'(reqReady), 64'd0);
    check("reset strobes", 64'({rspValid, rspErr, memRead, memWrite}), 64'd0);
    check("reset rspData", rspData, 64'd0);
    check("reset memAddr", memAddr, 64'd0);
    check("reset memWriteData", memWriteData, 64'd0);
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;
    #1 check("reqReady after reset", 64'(reqReady), 64'd1);

    issue(1'b0, 3'd0, 64'h0, 64'h0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FF83, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd4, 64'h0, 64'h0, 1'b1, mk(64'h83, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd3, 64'h0, 64'h0, 1'b1, mk(D0, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd1, 64'h2, 64'h0, 1'b1, mk(64'h0F05, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd2, 64'h4, 64'h0, 1'b1, mk(64'h009A_84B3, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd1, 64'h4, 64'h0, 1'b1, mk(64'hFFFF_FFFF_FFFF_84B3, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd6, 64'h4, 64'h0, 1'b1, mk(64'h009A_84B3, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd5, 64'h4, 64'h0, 1'b1, mk(64'h84B3, 1'b0, 2, 1, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'd1, 64'h1, 64'h0, 1'b1, mk(64'h0, 1'b1, 1, 0, 0, 0));
`else
    issue(1'b0, 3'd1, 64'h1, 64'h0, 1'b1, mk(64'h0534, 1'b0, 2, 1, 0, 0));
`endif
    issue(1'b1, 3'd0, 64'h1, 64'h1234_55AA, 1'b1, mk(64'h0, 1'b0, 3, 1, 1, 64'h009A_84B3_0F05_AA83));
    issue(1'b0, 3'd3, 64'h0, 64'h0, 1'b1, mk(64'h009A_84B3_0F05_AA83, 1'b0, 2, 1, 0, 0));
    issue(1'b1, 3'd3, 64'h40, 64'hFFFF, 1'b1, mk(64'h0, 1'b1, 1, 0, 0, 0));
    issue(1'b0, 3'd2, 64'h6, 64'h0, 1'b1, mk(64'h0, 1'b1, 1, 0, 0, 0));
    issue(1'b0, 3'd7, 64'h0, 64'h0, 1'b1, mk(64'h0, 1'b1, 1, 0, 0, 0));
    issue(1'b1, 3'd4, 64'h0, 64'h55, 1'b1, mk(64'h0, 1'b1, 1, 0, 0, 0));
    issue(1'b0, 3'd3, 64'h48, 64'h0, 1'b1, mk(64'h0, 1'b1, 1, 0, 0, 0));
    issue(1'b1, 3'd3, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 1'b1,
          mk(64'h0, 1'b0, 2, 0, 1, 64'hDEAD_BEEF_CAFE_F00D));
    issue(1'b1, 3'd2, 64'h14, 64'h1234_5678, 1'b1,
          mk(64'h0, 1'b0, 3, 1, 1, 64'h1234_5678_CAFE_F00D));
    issue(1'b0, 3'd3, 64'h10, 64'h0, 1'b1, mk(64'h1234_5678_CAFE_F00D, 1'b0, 2, 1, 0, 0));
    issue(1'b1, 3'd1, 64'h1E, 64'hBEEF, 1'b1,
          mk(64'h0, 1'b0, 3, 1, 1, 64'hBEEF_0504_0302_0100));
    issue(1'b0, 3'd3, 64'h18, 64'h0, 1'b1, mk(64'hBEEF_0504_0302_0100, 1'b0, 2, 1, 0, 0));

    // response stall: rspReady held low for 5 cycles in RESP
    drain();
    @(posedge clk); #1 rspReady = 1'b0;
    issue(1'b0, 3'd0, 64'h0, 64'h0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FF83, 1'b0, 2, 1, 0, 0));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rspValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("stall rspValid timeout", 64'd0, 64'd1);
    repeat (5) @(negedge clk);
    check("rspValid held during stall", 64'(rspValid), 64'd1);
    @(posedge clk); #1 rspReady = 1'b1;
    drain();

    // reset during the WR cycle of an sw must not commit the write
    issue(1'b1, 3'd2, 64'h8, 64'hFFFF_FFFF, 1'b0, mk(64'h0, 1'b0, 0, 0, 0, 0));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memWrite) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("sw memWrite timeout", 64'd0, 64'd1);
    #1 resetN = 1'b0;
    #1;
    check("memWrite drops on reset", 64'(memWrite), 64'd0);
    check("memAddr cleared on reset", memAddr, 64'd0);
    check("memWriteData cleared on reset", memWriteData, 64'd0);
    check("rspValid cleared on reset", 64'(rspValid), 64'd0);
    @(negedge clk);
    #2 resetN = 1'b1;
    #1 check("reqReady after mid-write reset", 64'(reqReady), 64'd1);
    issue(1'b0, 3'd3, 64'h8, 64'h0, 1'b1, mk(64'h1122_3344_5566_7788, 1'b0, 2, 1, 0, 0));
    issue(1'b0, 3'd3, 64'h0, 64'h0, 1'b1, mk(64'h009A_84B3_0F05_AA83, 1'b0, 2, 1, 0, 0));
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for `dataMemory`. It accepts one load or store request at a time from the pipeline MEM stage over a valid/ready handshake and drives the memory's doubleword port: `memAddr`, `writeData`, `memRead`, `memWrite` and `readData`. It performs RV64 sub-word handling: lane extraction with sign or zero extension for loads, and read-modify-write for byte, half and word stores, since `dataMemory` always writes 8 bytes. Responses return to the pipeline over a second valid/ready handshake, with an error flag.

## Interface
- `MEM_BYTES`, 64: size of the attached data memory in bytes (multiple of 8).
- `clk` in 1: clock, rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `reqValid` in 1: request present.
- `reqReady` out 1: unit can accept a request.
- `reqWrite` in 1: 1 = store, 0 = load.
- `reqFunct3` in 3: RV64 funct3 giving access size and signedness.
- `reqAddr` in 64: byte address.
- `reqWData` in 64: store data, right-aligned.
- `rspValid` out 1: response present.
- `rspReady` in 1: pipeline takes the response.
- `rspData` out 64: extended load result; 0 for stores and errors.
- `rspErr` out 1: request rejected; no memory write occurred.
- `memAddr` out 64: doubleword-aligned address to `dataMemory`.
- `memWriteData` out 64: to `dataMemory` `writeData`.
- `memRead` out 1: to `dataMemory` `memRead`.
- `memWrite` out 1: to `dataMemory` `memWrite`.
- `memReadData` in 64: from `dataMemory` `readData`, combinational.

## Operation
- **Decode**
  - base = `{reqAddr[63:3],3'b000}`; lane = `reqAddr[2:0]`; size = 1, 2, 4 or 8 bytes from `funct3[1:0]`.
  - Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - Stores: 000 sb, 001 sh, 010 sw, 011 sd.
- **Errors** (checked on accept, no memory cycle issued, go straight to RESP with `rspErr`=1):
  - load with funct3=111;
  - store with funct3[2]=1;
  - base ≥ `MEM_BYTES`;
  - lane+size > 8, i.e. the access crosses a doubleword;
  - misalignment, only when the configuration macro is defined.
- **FSM states:** IDLE, LOAD, RMW_RD, WR, RESP.
  - IDLE: `reqReady`=1. On accept, go to LOAD (load), WR (sd), RMW_RD (sb/sh/sw), or RESP (error). Request fields are latched on accept.
  - LOAD: `memRead`=1. Shift `memReadData` right by lane×8, truncate to size, sign- or zero-extend, and register the result into `rspData`. Next state is RESP.
  - RMW_RD: `memRead`=1. Register `memReadData` into the merge buffer. Next state is WR.
  - WR: `memWrite`=1. `memWriteData` is the merge buffer with bytes [lane, lane+size) replaced by `reqWData` low bytes. For sd, `memWriteData` is `reqWData` in full. Next state is RESP.
  - RESP: `rspValid`=1, held with `rspData` and `rspErr` stable until `rspReady`=1. Return to IDLE on that edge.
- `memRead` and `memWrite` are never both 1. Both are decoded from the state register, so they are 0 in IDLE and RESP.
- `memAddr` = latched base in LOAD, RMW_RD and WR; 0 otherwise.
- `memWriteData` = 0 outside WR.

## Timing
- Reset (async, immediate): state IDLE.
  - `reqReady`=1 once `resetN` is high; all other outputs 0, and the buffers are cleared.
- Reset during WR drops `memWrite` before the next edge, so no write is committed.
- Accept edge is cycle 0. `rspValid` first rises at:
  - load: cycle 2;
  - sd: cycle 2;
  - sb/sh/sw: cycle 3;
  - error: cycle 1.
- Back-to-back operation: a request can be accepted on the cycle after the RESP handshake completes, giving one IDLE bubble. There is no accept during RESP.
- `reqValid` while not ready is ignored; the requester must hold its request.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - Defined: any address with `reqAddr` mod size ≠ 0 gives `rspErr`=1.
  - Undefined: misaligned accesses contained within one doubleword are served normally. Doubleword-crossing accesses always error.

## Test plan
Memory is at its initial contents, so doubleword 0 = 0x009A84B30F053483.
- Loads at 0x0:
  - lb 0x0 → `rspData`=0xFFFFFFFFFFFFFF83, `rspErr`=0, `rspValid` at cycle 2;
  - lbu 0x0 → 0x83;
  - ld 0x0 → 0x009A84B30F053483.
- Loads at 0x2 and 0x4: lh 0x2 → 0x0F05; lw 0x4 → 0x00000000009A84B3; lh 0x4 → 0xFFFFFFFFFFFF84B3.
- sb 0x1 with data 0xAA:
  - one `memRead` cycle, then one `memWrite` cycle with `memWriteData`=0x009A84B30F05AA83, `rspValid` at cycle 3;
  - a following ld 0x0 returns 0x009A84B30F05AA83.
- Rejected requests:
  - sd 0x40 (`MEM_BYTES`=64) → `rspErr`=1 at cycle 1, `memWrite` never asserted;
  - lw 0x6 → `rspErr`=1 in both builds.
- lh 0x1:
  - with `LSU_MISALIGN_TRAP_EN` → `rspErr`=1;
  - without → `rspData`=0x0534.
- `rspReady` held low for 5 cycles in RESP → `rspValid` and `rspData` stable and `reqReady`=0 throughout. Separately, `resetN` pulsed low during WR of an sw → `memWrite` falls immediately and a later ld shows memory unchanged.
